nn_train_ctrl: RTL
==================

# nn_train_ctrl

Training sequencer for the backpropagation network. It drives the `select_initial` and `select_update` controls that every weight register (w1_xx, w2_xx) shares. It also steps the datapath through the forward, backward and update phases for each training sample, and counts samples and epochs until training completes. It sits between the top-level start/done handshake and the weight/neuron datapath.

## Interface
- `N_SAMPLES`, 4: training samples per epoch, range 1..256
- `N_EPOCHS`, 1000: maximum epochs, range 1..65535
- `FWD_LAT`, 3: cycles the datapath needs for the forward pass, range ≥1
- `BWD_LAT`, 2: cycles for delta/dw computation, range ≥1
- `ERR_THRESH`, 24'd205: epoch |error| sum threshold in Q6.10 (≈0.2); used only with the early-stop option
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle request to begin training
- `err`  in  16  signed Q6.10 output error of the current sample; used only with the early-stop option
- `select_initial`  out  1  one-cycle load of initial weights into all weight registers
- `select_update`  out  1  one-cycle application of dw to all weight registers
- `load_sample`  out  1  pulse: datapath latches sample `sample_idx`
- `fwd_en`  out  1  high during the forward phase
- `bwd_en`  out  1  high during the backward phase
- `sample_idx`  out  8  current sample index
- `epoch`  out  16  current epoch index
- `busy`  out  1  training in progress
- `done`  out  1  training finished; held as a level
- `early_stop`  out  1  done was reached by the threshold; always 0 without the option

## Operation
- States: IDLE, INIT, FWD, BWD, UPD, NEXT, DONE.
- IDLE: all strobes are 0. When `start`=1, go to INIT.
- INIT (1 cycle):
  - `select_initial`=1.
  - `sample_idx` and `epoch` clear to 0, and the error accumulator clears.
  - Go to FWD.
- FWD (`FWD_LAT` cycles):
  - `fwd_en`=1 throughout.
  - `load_sample`=1 in the first cycle only.
  - Then go to BWD.
- BWD (`BWD_LAT` cycles): `bwd_en`=1, then go to UPD.
- UPD (1 cycle): `select_update`=1, so every weight takes w+dw at the end of this cycle. The early-stop option samples `err` in this cycle.
- NEXT (1 cycle), decisions in priority order:
  - If `sample_idx` < `N_SAMPLES`-1: increment `sample_idx`, go to FWD.
  - Otherwise, at the end of an epoch:
    - If `epoch` = `N_EPOCHS`-1, or early stop triggers: go to DONE.
    - Otherwise: `sample_idx`←0, `epoch`++, clear the accumulator, go to FWD.
- DONE:
  - `done`=1, `busy`=0.
  - `sample_idx` and `epoch` hold their final values.
  - `start` goes to INIT, which restarts training with fresh initial weights.
- `start` is ignored in INIT through NEXT.
- `busy`=1 in INIT, FWD, BWD, UPD and NEXT.
- `select_initial` and `select_update` are never high in the same cycle.
- `epoch` saturates at its maximum and cannot wrap, because DONE is forced at `N_EPOCHS`-1.

## Timing
- Reset value of every output is 0; the state returns to IDLE.
- Reset mid-training aborts immediately, with no final update strobe.
- All outputs are registered, decoded from the state and counters.
- `select_initial` is high in the cycle after the cycle in which `start` is sampled.
- Cycles per sample: `FWD_LAT`+`BWD_LAT`+2.
- `done` rises 1 + `N_SAMPLES`·`N_EPOCHS`·(`FWD_LAT`+`BWD_LAT`+2) cycles after `start` is sampled.
- `done` and `busy` are never both high.

## Configuration
- Macro: `NN_TRAIN_CTRL_EARLY_STOP_EN`.
- Defined:
  - In UPD, |`err`| is added to a 24-bit unsigned accumulator.
  - |−32768| is treated as 32767, and the accumulator saturates at 2^24−1.
  - In NEXT at the end of an epoch, if the sum < `ERR_THRESH`, go to DONE with `early_stop`=1.
  - `early_stop` clears on INIT.
- Undefined:
  - The accumulator and comparator are absent, and `err` is unused.
  - `early_stop` is tied to 0.
  - Training always runs `N_EPOCHS` epochs.

## Structure
- Package `nn_pkg` holds:
  - Q6.10 constants: `NN_W`=16, `NN_FRAC`=10.
  - `ERR_ACC_W`=24.
  - The state enum type.
- One sub-module, `nn_phase_timer`: a loadable down-counter with a `zero` flag, reused for the FWD and BWD phase lengths. The counters and FSM stay in the top module.

## Test plan
- Bench parameters: `N_SAMPLES`=4, `N_EPOCHS`=2, `FWD_LAT`=3, `BWD_LAT`=2.
- Basic run: `start` pulse → `select_initial` exactly one cycle; 8 `select_update` pulses spaced 7 cycles apart; `done`=1 57 cycles after `start`; final `sample_idx`=3, `epoch`=1.
- Strobe check: for every sample, `load_sample` is coincident with the first `fwd_en` cycle; `fwd_en` is high for 3 cycles, then `bwd_en` for 2, then `select_update` for 1.
- Start while busy: `start` pulsed at cycles 5 and 20 → the run is unchanged, `done` still at 57.
- Reset mid-run: `reset` at cycle 30 → the next cycle has all outputs 0 and the state is IDLE; a new `start` reruns and `done` rises 57 cycles after it.
- Restart from DONE: `start` in DONE → `done` falls, `select_initial` pulses, counters return to 0.
- Early stop (macro defined, `ERR_THRESH`=205): `err`=+40 on every sample of epoch 0 (sum 160) → `done` and `early_stop` after 29 cycles. Then `err`=−32768 on all samples of a new run → no early stop, the run is full length, and the accumulator is not negative and does not overflow.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared fixed-point constants and FSM state type for the
// backprop training controller.
package nn_pkg;

  localparam int NN_W      = 16;
  localparam int NN_FRAC   = 10;
  localparam int ERR_ACC_W = 24;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_FWD  = 3'd2,
    S_BWD  = 3'd3,
    S_UPD  = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } nn_state_t;

endpackage

// File: rtl/nn_phase_timer.sv
// Loadable down-counter with a zero flag, shared by the
// forward and backward phase lengths.
module nn_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nn_train_ctrl.sv
// Training sequencer: INIT, then FWD/BWD/UPD/NEXT per sample.
// NN_TRAIN_CTRL_EARLY_STOP_EN adds the epoch-error early stop.
module nn_train_ctrl
  import nn_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int N_EPOCHS  = 1000,
  parameter int FWD_LAT   = 3,
  parameter int BWD_LAT   = 2,
  parameter logic [ERR_ACC_W-1:0] ERR_THRESH = 24'd205
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NN_W-1:0] err,
  output logic            select_initial,
  output logic            select_update,
  output logic            load_sample,
  output logic            fwd_en,
  output logic            bwd_en,
  output logic [7:0]      sample_idx,
  output logic [15:0]     epoch,
  output logic            busy,
  output logic            done,
  output logic            early_stop
);

  localparam int TW = 16;

  nn_state_t r_state;
  nn_state_t w_nxt;
  logic      w_zero;
  logic      w_tload;
  logic [TW-1:0] w_tval;
  logic      w_last_smp;
  logic      w_last_ep;
  logic      w_es;
  logic      w_new_ep;

  assign w_last_smp = (sample_idx == 8'(N_SAMPLES - 1));
  assign w_last_ep  = (epoch == 16'(N_EPOCHS - 1));

`ifdef NN_TRAIN_CTRL_EARLY_STOP_EN
  logic [ERR_ACC_W-1:0] r_acc;
  logic [NN_W-1:0]      w_abs;
  logic [ERR_ACC_W:0]   w_sum;

  always_comb begin
    w_abs = err;
    if (err[NN_W-1])
      w_abs = (err == 16'h8000) ? 16'h7fff : (~err + 1'b1);
  end

  assign w_sum = {1'b0, r_acc} + (ERR_ACC_W+1)'(w_abs);
  assign w_es  = (r_acc < ERR_THRESH);

  always_ff @(posedge clk) begin
    if (reset)
      r_acc <= '0;
    else if (w_nxt == S_INIT || w_new_ep)
      r_acc <= '0;
    else if (r_state == S_UPD)
      r_acc <= w_sum[ERR_ACC_W] ? '1 : w_sum[ERR_ACC_W-1:0];
  end
`else
  logic w_unused_err;
  assign w_unused_err = ^{err, ERR_THRESH};
  assign w_es = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): if (start) w_nxt = S_INIT;
      (r_state == S_INIT): w_nxt = S_FWD;
      (r_state == S_FWD):  if (w_zero) w_nxt = S_BWD;
      (r_state == S_BWD):  if (w_zero) w_nxt = S_UPD;
      (r_state == S_UPD):  w_nxt = S_NEXT;
      (r_state == S_NEXT):
        if (!w_last_smp)            w_nxt = S_FWD;
        else if (w_last_ep || w_es) w_nxt = S_DONE;
        else                        w_nxt = S_FWD;
      (r_state == S_DONE): if (start) w_nxt = S_INIT;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_new_ep = (r_state == S_NEXT) && w_last_smp &&
                    (w_nxt == S_FWD);

  // Each phase reloads the timer on entry; it exits at zero.
  assign w_tload = ((w_nxt == S_FWD) && (r_state != S_FWD)) ||
                   ((w_nxt == S_BWD) && (r_state != S_BWD));
  assign w_tval  = (w_nxt == S_FWD) ? TW'(FWD_LAT - 1)
                                    : TW'(BWD_LAT - 1);

  nn_phase_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tload),
    .i_val  (w_tval),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      sample_idx     <= '0;
      epoch          <= '0;
      select_initial <= 1'b0;
      select_update  <= 1'b0;
      load_sample    <= 1'b0;
      fwd_en         <= 1'b0;
      bwd_en         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      early_stop     <= 1'b0;
    end else begin
      r_state        <= w_nxt;
      select_initial <= (w_nxt == S_INIT);
      select_update  <= (w_nxt == S_UPD);
      load_sample    <= (w_nxt == S_FWD) && (r_state != S_FWD);
      fwd_en         <= (w_nxt == S_FWD);
      bwd_en         <= (w_nxt == S_BWD);
      busy           <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      done           <= (w_nxt == S_DONE);
      if (w_nxt == S_INIT) begin
        sample_idx <= '0;
        epoch      <= '0;
        early_stop <= 1'b0;
      end else if (w_new_ep) begin
        sample_idx <= '0;
        epoch      <= epoch + 1'b1;
      end else if (r_state == S_NEXT && w_nxt == S_FWD) begin
        sample_idx <= sample_idx + 1'b1;
      end
      if (r_state == S_NEXT && w_last_smp && w_es)
        early_stop <= 1'b1;
    end
  end

endmodule
